// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver: advances one digit per rising edge of a scan strobe
// sampled in the clk_in domain, latching the displayed value once per frame.
module seg_scan_display #(
    parameter int DIGITS   = 8,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  scan_clk_in,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [IW-1:0]       idx_q,  idx_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   dpl_q,  dpl_d;
    logic [DIGITS-1:0]   an_q,   an_d;
    logic [6:0]          seg_q,  seg_d;
    logic                dp_q,   dp_d;
    logic                fd_q,   fd_d;
    logic                prev_q;

    logic                step, wrap, upper_zero, blank;
    logic [4*DIGITS-1:0] eff_data;
    logic [DIGITS-1:0]   eff_dp;
    logic [3:0]          nib;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        idx_d      = idx_q;
        data_d     = data_q;
        dpl_d      = dpl_q;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        fd_d       = 1'b0;
        step       = scan_clk_in & ~prev_q;
        wrap       = (idx_q == LAST);
        eff_data   = data_q;
        eff_dp     = dpl_q;
        nib        = 4'h0;
        upper_zero = 1'b1;
        blank      = 1'b0;

        if (!enable) begin
            idx_d = LAST;
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else if (step) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
            if (wrap) begin
                // The new frame's digit 0 decodes straight from the inputs being latched.
                data_d   = data_in;
                dpl_d    = dp_in;
                fd_d     = 1'b1;
                eff_data = data_in;
                eff_dp   = dp_in;
            end
            nib = eff_data[4*int'(idx_d) +: 4];
            for (int j = 0; j < DIGITS; j++) begin
                if (j >= int'(idx_d) && eff_data[4*j +: 4] != 4'h0) upper_zero = 1'b0;
            end
            blank = LZ_BLANK && (idx_d != '0) && upper_zero;
            if (blank) begin
                an_d  = '1;
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(DIGITS'(1) << idx_d);
                seg_d = hex7(nib);
                dp_d  = ~eff_dp[idx_d];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            idx_q  <= LAST;
            data_q <= '0;
            dpl_q  <= '0;
            an_q   <= '1;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
            fd_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            dpl_q  <= dpl_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fd_q   <= fd_d;
            prev_q <= scan_clk_in;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues the expected outputs of every
// cycle, a monitor compares them shortly after each clock edge.
module tb_seg_scan_display;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    localparam exp_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

    logic        clk = 1'b0;
    logic        rst, scan, enable;
    logic [31:0] data;
    logic [7:0]  dpi;
    logic [7:0]  an_w;
    logic [6:0]  seg_w;
    logic        dp_w, fd_w;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(8), .LZ_BLANK(1'b1)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .scan_clk_in (scan),
        .enable      (enable),
        .data_in     (data),
        .dp_in       (dpi),
        .an          (an_w),
        .seg         (seg_w),
        .dp          (dp_w),
        .frame_done  (fd_w)
    );

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (an_w === e.an && seg_w === e.seg && dp_w === e.dp && fd_w === e.fd) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_%0d: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                         n_cycle, an_w, seg_w, dp_w, fd_w, e.an, e.seg, e.dp, e.fd);
            end
            n_cycle++;
        end
    end

    function automatic exp_t digit(input int i, input logic [6:0] s, input logic d, input logic f);
        logic [7:0] one;
        one   = 8'h01;
        digit = '{an: ~(one << i), seg: s, dp: d, fd: f};
    endfunction

    // Called at a falling edge: drives one cycle's inputs and queues what that edge must produce.
    task automatic cyc(input logic r, input logic s, input exp_t e);
        rst  = r;
        scan = s;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rise(input exp_t e);
        exp_t h;
        h    = cur;
        h.fd = 1'b0;
        cyc(1'b0, 1'b0, h);
        cyc(1'b0, 1'b1, e);
        cur    = e;
        cur.fd = 1'b0;
    endtask

    logic [6:0] t2 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        rst = 1'b1; scan = 1'b0; enable = 1'b1; data = '0; dpi = '0;
        @(negedge clk);

        // reset with strobe toggling
        cyc(1'b1, 1'b0, DARK);
        cyc(1'b1, 1'b1, DARK);
        cyc(1'b1, 1'b0, DARK);
        cur = DARK;
        cyc(1'b0, 1'b0, DARK);

        // full frame of 12345678
        data = 32'h12345678;
        for (int i = 0; i < 8; i++) rise(digit(i, t2[i], 1'b1, i == 0));

        // leading-zero blanking with a lit decimal point on digit 0
        data = 32'h000000A0; dpi = 8'h01;
        rise(digit(0, 7'h40, 1'b0, 1'b1));
        rise(digit(1, 7'h08, 1'b1, 1'b0));
        for (int i = 2; i < 8; i++) rise(DARK);
        data = 32'h0; dpi = 8'h00;
        rise(digit(0, 7'h40, 1'b1, 1'b1));
        for (int i = 1; i < 8; i++) rise(DARK);

        // inner zeros stay lit below a nonzero nibble
        data = 32'h00100000;
        for (int i = 0; i < 5; i++) rise(digit(i, 7'h40, 1'b1, i == 0));
        rise(digit(5, 7'h79, 1'b1, 1'b0));
        rise(DARK);
        rise(DARK);

        // mid-frame data change is ignored until the wrap
        data = 32'h12345678;
        for (int i = 0; i < 4; i++) rise(digit(i, t2[i], 1'b1, i == 0));
        data = 32'hFFFFFFFF;
        for (int i = 4; i < 8; i++) rise(digit(i, t2[i], 1'b1, 1'b0));
        rise(digit(0, 7'h0E, 1'b1, 1'b1));

        // disable at digit 5, strobe ignored while dark, fresh frame on re-enable
        for (int i = 1; i < 6; i++) rise(digit(i, 7'h0E, 1'b1, 1'b0));
        enable = 1'b0;
        cyc(1'b0, 1'b0, DARK);
        cur = DARK;
        cyc(1'b0, 1'b1, DARK);
        cyc(1'b0, 1'b0, DARK);
        enable = 1'b1;
        rise(digit(0, 7'h0E, 1'b1, 1'b1));

        // reset coinciding with the step to digit 4
        for (int i = 1; i < 4; i++) rise(digit(i, 7'h0E, 1'b1, 1'b0));
        cyc(1'b0, 1'b0, cur);
        cyc(1'b1, 1'b1, DARK);
        cur = DARK;
        cyc(1'b0, 1'b0, DARK);
        rise(digit(0, 7'h0E, 1'b1, 1'b1));

        // strobe held high: no further steps
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, cur);
        rise(digit(1, 7'h0E, 1'b1, 1'b0));
        cyc(1'b0, 1'b0, cur);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d queued entries, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
